// File: rtl/hazard_unit.sv
// Load-use / RAW hazard detector for the 5-stage MIPS pipeline: drives the decoder stall,
// PC and IF/ID enables, wrong-path flush, and a saturating stall-cycle statistic.
module hazard_unit #(
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             redirect,
  output logic             stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] rd;
  } ex_shadow_t;

  // The load flag is only ever consulted in EX, so MEM keeps just the write attributes.
  // WB is not shadowed at all: the register file writes before it is read.
  typedef struct packed {
    logic       v;
    logic       rw;
    logic [4:0] rd;
  } mem_shadow_t;

  ex_shadow_t  ex_q;
  mem_shadow_t mem_q;

  logic raw_ex;
  logic raw_mem;
  logic hz;

  always_comb begin
    raw_ex  = 1'b0;
    raw_mem = 1'b0;
    if (ex_q.v && ex_q.rw && (ex_q.rd != 5'd0)) begin
      raw_ex = (id_use_rs && (ex_q.rd == id_rs)) || (id_use_rt && (ex_q.rd == id_rt));
    end
    if (mem_q.v && mem_q.rw && (mem_q.rd != 5'd0)) begin
      raw_mem = (id_use_rs && (mem_q.rd == id_rs)) || (id_use_rt && (mem_q.rd == id_rt));
    end
  end

  always_comb begin
    if (FORWARDING != 0) begin
      hz = id_valid && ex_q.mr && raw_ex;
    end else begin
      hz = id_valid && (raw_ex || raw_mem);
    end
  end

  // A redirect makes the ID instruction wrong-path, so it never needs to wait.
  assign stall      = hz && !redirect;
  assign pc_en      = !stall;
  assign ifid_en    = !stall;
  assign ifid_flush = redirect;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      if (stall || redirect) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{v: id_valid, rw: id_regwrite, mr: id_memread, rd: id_rd};
      end
      mem_q <= '{v: ex_q.v, rw: ex_q.rw, rd: ex_q.rd};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: forwarding, no-forwarding and a narrow-counter
// instance share one directed stimulus stream and are compared against a history model.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       redirect;

  logic        stallV[3];
  logic        pcEnV[3];
  logic        ifidEnV[3];
  logic        flushV[3];
  logic [15:0] cntFwd;
  logic [15:0] cntNoFwd;
  logic [1:0]  cntSat;

  int  checks = 0;
  int  errors = 0;
  bit  checkEn = 1'b0;

  always #5 CLK = ~CLK;

  hazard_unit #(.FORWARDING(1), .CNT_W(16)) dutFwd (
    .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
    .stall(stallV[0]), .pc_en(pcEnV[0]), .ifid_en(ifidEnV[0]),
    .ifid_flush(flushV[0]), .stall_cycles(cntFwd));

  hazard_unit #(.FORWARDING(0), .CNT_W(16)) dutNoFwd (
    .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
    .stall(stallV[1]), .pc_en(pcEnV[1]), .ifid_en(ifidEnV[1]),
    .ifid_flush(flushV[1]), .stall_cycles(cntNoFwd));

  hazard_unit #(.FORWARDING(1), .CNT_W(2)) dutSat (
    .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
    .stall(stallV[2]), .pc_en(pcEnV[2]), .ifid_en(ifidEnV[2]),
    .ifid_flush(flushV[2]), .stall_cycles(cntSat));

  // Model: per instance, the last two instructions that actually issued (age 0 = now in EX).
  typedef struct {
    bit v;
    bit rw;
    bit mr;
    int rd;
  } instrT;

  instrT hist[3][2];
  int    expCount[3] = '{0, 0, 0};
  int    maxCount[3] = '{65535, 65535, 3};
  bit    isFwd[3]    = '{1'b1, 1'b0, 1'b1};

  function automatic bit readsFrom(instrT e);
    if (!(e.v && e.rw && e.rd != 0)) return 1'b0;
    return (id_use_rs && e.rd == int'(id_rs)) || (id_use_rt && e.rd == int'(id_rt));
  endfunction

  function automatic bit expectStall(int m);
    bit hz;
    if (isFwd[m]) hz = id_valid && hist[m][0].mr && readsFrom(hist[m][0]);
    else          hz = id_valid && (readsFrom(hist[m][0]) || readsFrom(hist[m][1]));
    return hz && !redirect;
  endfunction

  function automatic int actualCount(int m);
    if (m == 0) return int'(cntFwd);
    if (m == 1) return int'(cntNoFwd);
    return int'(cntSat);
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance the model on every edge the DUT would, and clear it with the async reset.
  always @(posedge CLK or negedge RSTn) begin
    for (int m = 0; m < 3; m++) begin
      if (!RSTn) begin
        hist[m][0]  = '{0, 0, 0, 0};
        hist[m][1]  = '{0, 0, 0, 0};
        expCount[m] = 0;
      end else begin
        bit s;
        s = expectStall(m);
        hist[m][1] = hist[m][0];
        if (s || redirect) hist[m][0] = '{0, 0, 0, 0};
        else hist[m][0] = '{id_valid, id_regwrite, id_memread, int'(id_rd)};
        if (s && expCount[m] < maxCount[m]) expCount[m]++;
      end
    end
  end

  // Mid-cycle comparison of every instance against the model.
  always @(negedge CLK) begin
    if (checkEn) begin
      for (int m = 0; m < 3; m++) begin
        bit s;
        s = RSTn ? expectStall(m) : 1'b0;
        checkOutput($sformatf("stall[%0d]", m), int'(stallV[m]), int'(s));
        checkOutput($sformatf("pc_en[%0d]", m), int'(pcEnV[m]), int'(!s));
        checkOutput($sformatf("ifid_en[%0d]", m), int'(ifidEnV[m]), int'(!s));
        checkOutput($sformatf("ifid_flush[%0d]", m), int'(flushV[m]), int'(redirect));
        checkOutput($sformatf("stall_cycles[%0d]", m), actualCount(m), expCount[m]);
      end
    end
  end

  task automatic setInputs(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit redir);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    redirect    = redir;
  endtask

  task automatic applyStimulus(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit redir);
    setInputs(v, rs, rt, urs, urt, rd, rw, mr, redir);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadTo(int rd);
    applyStimulus(1, 1, 2, 1, 0, rd, 1, 1, 0);
  endtask

  task automatic aluTo(int rd);
    applyStimulus(1, 1, 2, 1, 1, rd, 1, 0, 0);
  endtask

  task automatic useRs(int rs);
    applyStimulus(1, rs, 0, 1, 1, 10, 1, 0, 0);
  endtask

  task automatic doReset();
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    RSTn = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  initial begin
    RSTn = 1'b1;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("reset stall", int'(stallV[0]), 0);
    checkOutput("reset pc_en", int'(pcEnV[0]), 1);
    checkOutput("reset ifid_en", int'(ifidEnV[1]), 1);
    checkOutput("reset count", int'(cntNoFwd), 0);
    checkEn = 1'b1;
    doReset();
    idle();

    // lw $8 then a user of $8, held in ID while stalled.
    loadTo(8);
    setInputs(1, 8, 0, 1, 1, 10, 1, 0, 0);
    #2;
    checkOutput("lw-use stall fwd", int'(stallV[0]), 1);
    checkOutput("lw-use pc_en fwd", int'(pcEnV[0]), 0);
    checkOutput("lw-use stall nofwd", int'(stallV[1]), 1);
    @(posedge CLK);
    #1;
    useRs(8);
    useRs(8);
    checkOutput("lw-use count fwd", int'(cntFwd), 1);
    checkOutput("lw-use count nofwd", int'(cntNoFwd), 2);

    // ALU producer then consumer: only the no-forwarding pipe waits, twice.
    doReset();
    aluTo(8);
    useRs(8);
    useRs(8);
    useRs(8);
    checkOutput("alu-use count fwd", int'(cntFwd), 0);
    checkOutput("alu-use count nofwd", int'(cntNoFwd), 2);

    // Producer of $9, independent instruction, rt user of $9: one stall without forwarding.
    doReset();
    aluTo(9);
    aluTo(12);
    applyStimulus(1, 3, 9, 1, 1, 13, 1, 0, 0);
    applyStimulus(1, 3, 9, 1, 1, 13, 1, 0, 0);
    checkOutput("gap-use count nofwd", int'(cntNoFwd), 1);

    // Writes to $0 never create a hazard.
    doReset();
    loadTo(0);
    useRs(0);
    useRs(0);
    checkOutput("zero-reg count fwd", int'(cntFwd), 0);
    checkOutput("zero-reg count nofwd", int'(cntNoFwd), 0);

    // Load-use coinciding with a redirect: flush wins, EX gets a bubble.
    doReset();
    loadTo(8);
    setInputs(1, 8, 0, 1, 1, 10, 1, 0, 1);
    #2;
    checkOutput("redirect stall", int'(stallV[0]), 0);
    checkOutput("redirect flush", int'(flushV[0]), 1);
    @(posedge CLK);
    #1;
    setInputs(1, 8, 0, 1, 1, 10, 1, 0, 0);
    #2;
    checkOutput("post-redirect bubble", int'(stallV[0]), 0);
    @(posedge CLK);
    #1;
    checkOutput("redirect count fwd", int'(cntFwd), 0);

    // Unused rs field and an invalid ID slot both ignore a matching load.
    doReset();
    loadTo(8);
    applyStimulus(1, 8, 3, 0, 1, 10, 1, 0, 0);
    loadTo(8);
    applyStimulus(0, 8, 0, 1, 0, 10, 1, 0, 0);
    checkOutput("no-use count fwd", int'(cntFwd), 0);

    // Repeated load-use pairs saturate the narrow counter.
    doReset();
    for (int i = 0; i < 5; i++) begin
      loadTo(8);
      useRs(8);
      useRs(8);
      useRs(8);
    end
    checkOutput("sat count narrow", int'(cntSat), 3);
    checkOutput("sat count fwd", int'(cntFwd), 5);
    checkOutput("sat count nofwd", int'(cntNoFwd), 10);

    // Asynchronous reset in the middle of a stall cycle.
    loadTo(8);
    setInputs(1, 8, 0, 1, 1, 10, 1, 0, 0);
    @(negedge CLK);
    checkOutput("pre-reset stall", int'(stallV[0]), 1);
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("async reset stall", int'(stallV[0]), 0);
    checkOutput("async reset pc_en", int'(pcEnV[1]), 1);
    checkOutput("async reset count fwd", int'(cntFwd), 0);
    checkOutput("async reset count sat", int'(cntSat), 0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    idle();
    idle();

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Produces the `stall` input consumed by the ID-stage control decoder, plus the PC and IF/ID enable/flush controls of the 5-stage MIPS pipeline.
- Keeps a private shadow of the destination-register and write/load attributes for instructions in EX, MEM and WB.
- Compares that shadow against the source registers of the instruction in ID, and asserts stall on read-after-write hazards the datapath cannot resolve.
- Squashes wrong-path instructions on a redirect and keeps a saturating stall-cycle statistic.

Parameters:
- FORWARDING, 1, 1 = full EX/MEM forwarding present (stall on load-use only); 0 = no forwarding (stall on any RAW against EX or MEM).
- CNT_W, 16, width of the stall statistic counter.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction (0 = bubble).
- id_rs  input  5  rs field of ID instruction.
- id_rt  input  5  rt field of ID instruction.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_rd  input  5  final destination of ID instruction, after the RegDst/SavePC mux (31 for jal).
- id_regwrite  input  1  ID instruction writes the register file (decoder RegWrite with stall forced 0).
- id_memread  input  1  ID instruction is a load.
- redirect  input  1  taken branch/jump/jr resolved this cycle; the ID and IF contents are wrong-path.
- stall  output  1  to decoder: force ID control to NOP this cycle.
- pc_en  output  1  PC register write enable.
- ifid_en  output  1  IF/ID register write enable.
- ifid_flush  output  1  IF/ID register loads a bubble next edge.
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Shadow stages ex, mem, wb, each {v, rw, mr, rd}. Reset (async, RSTn=0): all fields 0, stall_cycles=0.
- Outputs during and just after reset: stall=0, pc_en=1, ifid_en=1, ifid_flush=0.
- match(S,r) = S.v & S.rw & (S.rd!=0) & (S.rd==r). Register $0 never causes a hazard.
- raw(S) = (id_use_rs & match(S,id_rs)) | (id_use_rt & match(S,id_rt)).
- FORWARDING=1: hz = id_valid & ex.mr & raw(ex).
- FORWARDING=0: hz = id_valid & (raw(ex) | raw(mem)).
- WB is never checked in either mode: the register file is write-before-read.
- stall = hz & ~redirect. Redirect wins because the ID instruction is wrong-path. All outputs are combinational from shadow state and current inputs.
- pc_en = ifid_en = ~stall. ifid_flush = redirect.
- Each edge:
  - ex <= (stall | redirect) ? 0 : {id_valid, id_regwrite, id_memread, id_rd}.
  - mem <= ex; wb <= mem.
  - A stall inserts exactly one bubble per stalled cycle.
- Latency of the load-use penalty:
  - FORWARDING=1: lw followed by a dependent instruction costs 1 stall cycle.
  - FORWARDING=0: the penalty is 2 cycles after a producer; 1 cycle if an independent instruction intervenes.
- stall_cycles increments by 1 on each edge where stall=1. It holds at 2^CNT_W-1 (no wrap).
- stall and redirect asserted together: stall=0, no count increment, ex gets a bubble.
- Reset mid-stall: shadow cleared, so stall drops immediately while RSTn=0, counter cleared.

Test Plan:
- FORWARDING=1: `lw $8` issued (rd=8, memread=1), next cycle ID uses rs=8 -> stall=1, pc_en=0, ifid_en=0 for exactly 1 cycle; ex bubble; stall_cycles=1; then stall=0.
- FORWARDING=1: `addu $8` (memread=0) followed by a user of $8 -> stall never asserted. FORWARDING=0, same sequence -> stall=1 for 2 cycles, stall_cycles=2.
- FORWARDING=0: producer of $9, one independent instruction, then a user of rt=9 -> stall=1 for 1 cycle. A producer to $0 followed by a user of $0 -> no stall.
- Load-use hazard present with redirect=1 the same cycle -> stall=0, ifid_flush=1, ex loaded with bubble (v=0), counter unchanged.
- id_use_rs=0 with rs matching a load in EX -> no stall. id_valid=0 with a matching rs -> no stall.
- Preset stall_cycles to all-ones (force), continuous stall -> stays 0xFFFF. RSTn pulsed low mid-stall -> stall=0 and stall_cycles=0 asynchronously, before the next CLK edge.
